// File: rtl/symbol_seq_tx_if.sv
// Bus between the symbol sequence transmitter and whatever drives/observes it.
// The master side issues start/sequence/repeat/hold; the slave side returns the symbol stream.
interface symbol_seq_tx_if #(
    parameter int SYM_W   = 4,
    parameter int SEQ_LEN = 4,
    parameter int CNT_W   = 4
) ();
    logic                     start_i;
    logic [SYM_W*SEQ_LEN-1:0] seq_i;
    logic [CNT_W-1:0]         rep_i;
    logic                     hold_i;
    logic [SYM_W-1:0]         data_o;
    logic                     valid_o;
    logic                     busy_o;
    logic                     done_o;

    modport master (
        output start_i, seq_i, rep_i, hold_i,
        input  data_o, valid_o, busy_o, done_o
    );

    modport slave (
        input  start_i, seq_i, rep_i, hold_i,
        output data_o, valid_o, busy_o, done_o
    );
endinterface

// File: rtl/symbol_seq_tx.sv
// Symbol sequence transmitter: sends a latched SEQ_LEN-symbol sequence rep_i times,
// one symbol per cycle, with GAP idle cycles between repetitions and a done pulse at the end.
module symbol_seq_tx #(
    parameter int SYM_W   = 4,
    parameter int SEQ_LEN = 4,
    parameter int GAP     = 2,
    parameter int CNT_W   = 4
) (
    input  logic           clk,
    input  logic           rst,
    symbol_seq_tx_if.slave bus
);
    localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t                   state;
    logic [SYM_W*SEQ_LEN-1:0] seq_q;
    logic [IDX_W-1:0]         sym_idx;
    logic [CNT_W-1:0]         rep_cnt;
    logic [GAP_W-1:0]         gap_cnt;
    logic [SYM_W-1:0]         data_q;
    logic                     valid_q;
    logic                     busy_q;
    logic                     done_q;

    logic [IDX_W-1:0]         idx_nxt;
    logic [CNT_W-1:0]         rep_dec;
    logic [SYM_W-1:0]         sym_first;
    logic [SYM_W-1:0]         sym_next;

    always_comb begin
        idx_nxt   = sym_idx + 1'b1;
        rep_dec   = rep_cnt - 1'b1;
        sym_first = seq_q[SYM_W-1:0];
        sym_next  = seq_q[idx_nxt*SYM_W +: SYM_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            sym_idx <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        seq_q   <= bus.seq_i;
                        rep_cnt <= bus.rep_i;
                        sym_idx <= '0;
                        gap_cnt <= '0;
                        busy_q  <= 1'b1;
                        if (bus.rep_i != '0) begin
                            state   <= ST_SEND;
                            data_q  <= bus.seq_i[SYM_W-1:0];
                            valid_q <= 1'b1;
                        end else begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (!bus.hold_i) begin
                        if (sym_idx == IDX_LAST) begin
                            rep_cnt <= rep_dec;
                            if (rep_dec == '0) begin
                                state   <= ST_DONE;
                                done_q  <= 1'b1;
                                valid_q <= 1'b0;
                                data_q  <= '0;
                            end else if (GAP == 0) begin
                                sym_idx <= '0;
                                data_q  <= sym_first;
                            end else begin
                                state   <= ST_GAP;
                                gap_cnt <= '0;
                                valid_q <= 1'b0;
                                data_q  <= '0;
                            end
                        end else begin
                            sym_idx <= idx_nxt;
                            data_q  <= sym_next;
                        end
                    end
                end
                ST_GAP: begin
                    if (!bus.hold_i) begin
                        if (gap_cnt == GAP_LAST) begin
                            state   <= ST_SEND;
                            sym_idx <= '0;
                            data_q  <= sym_first;
                            valid_q <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A stall must blank valid in the very cycle hold_i is high while the symbol stays
    // on data_o, so valid is the registered flag masked by the live hold input.
    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q & ~bus.hold_i;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
endmodule

// File: tb/tb_symbol_seq_tx.sv
// Randomized bench for symbol_seq_tx: a GAP=2 and a GAP=0 instance share one stimulus
// stream and are compared cycle by cycle against a slot-list model of the transmission.
module tb_symbol_seq_tx;
    localparam int GAPC  = -1;
    localparam int DONEC = -2;
    localparam int BUDGET = 700;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] seq;
    logic [3:0]  rep;
    logic        hold;

    always #5 clk = ~clk;

    symbol_seq_tx_if #(.SYM_W(4), .SEQ_LEN(4), .CNT_W(4)) bus2 ();
    symbol_seq_tx_if #(.SYM_W(4), .SEQ_LEN(4), .CNT_W(4)) bus0 ();

    assign bus2.start_i = start;
    assign bus2.seq_i   = seq;
    assign bus2.rep_i   = rep;
    assign bus2.hold_i  = hold;
    assign bus0.start_i = start;
    assign bus0.seq_i   = seq;
    assign bus0.rep_i   = rep;
    assign bus0.hold_i  = hold;

    symbol_seq_tx #(.SYM_W(4), .SEQ_LEN(4), .GAP(2), .CNT_W(4)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    symbol_seq_tx #(.SYM_W(4), .SEQ_LEN(4), .GAP(0), .CNT_W(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int slots[2][$];
    int ptr[2];
    int gapv[2] = '{2, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // {busy, done, valid, data}
    function automatic logic [6:0] obs(input int w);
        if (w == 0) return {bus2.busy_o, bus2.done_o, bus2.valid_o, bus2.data_o};
        return {bus0.busy_o, bus0.done_o, bus0.valid_o, bus0.data_o};
    endfunction

    function automatic logic [6:0] expv(input int w);
        int code;
        if (ptr[w] >= slots[w].size()) return 7'd0;
        code = slots[w][ptr[w]];
        if (code == DONEC) return 7'b1100000;
        if (code == GAPC)  return 7'b1000000;
        return {1'b1, 1'b0, ~hold, code[3:0]};
    endfunction

    task automatic run_tx(input logic [15:0] s, input logic [3:0] r, input int hold_pct,
                          input logic [31:0] hold_mask, input bit noise, input bit lb);
        int          cyc;
        int          held[2];
        int          done_at[2];
        int          hits[2];
        int          nv[2];
        int          code;
        logic [15:0] hist[2];
        logic [15:0] target;
        logic [6:0]  o;
        target = {s[3:0], s[7:4], s[11:8], s[15:12]};
        for (int w = 0; w < 2; w++) begin
            slots[w].delete();
            for (int rr = 0; rr < int'(r); rr++) begin
                for (int k = 0; k < 4; k++) slots[w].push_back(int'(s[k*4 +: 4]));
                if (rr < int'(r) - 1)
                    for (int g = 0; g < gapv[w]; g++) slots[w].push_back(GAPC);
            end
            slots[w].push_back(DONEC);
            ptr[w] = 0; held[w] = 0; done_at[w] = -1; hits[w] = 0; nv[w] = 0; hist[w] = '0;
        end
        @(posedge clk); #1;
        start = 1'b1; seq = s; rep = r; hold = 1'($urandom_range(0, 1));
        @(negedge clk);
        for (int w = 0; w < 2; w++) check($sformatf("idle_pre_d%0d", w), 32'(obs(w)), 32'd0);
        @(posedge clk);
        cyc = 1;
        while ((ptr[0] < slots[0].size() || ptr[1] < slots[1].size()) && cyc <= BUDGET) begin
            #1;
            start = 1'b0;
            hold  = ((cyc < 32) && hold_mask[cyc]) || ($urandom_range(1, 100) <= hold_pct);
            if (noise && ptr[0] < slots[0].size() && ptr[1] < slots[1].size()) begin
                seq = 16'($urandom);
                rep = 4'($urandom);
                if ($urandom_range(0, 3) == 0) start = 1'b1;
            end
            @(negedge clk);
            for (int w = 0; w < 2; w++) begin
                o = obs(w);
                check($sformatf("d%0d_c%0d", w, cyc), 32'(o), 32'(expv(w)));
                if (o[5] && done_at[w] < 0) done_at[w] = cyc;
                if (o[4]) begin
                    hist[w] = {hist[w][11:0], o[3:0]};
                    nv[w]++;
                    if (nv[w] >= 4 && hist[w] == target) hits[w]++;
                end
                if (hold && ptr[w] < slots[w].size() && slots[w][ptr[w]] != DONEC) held[w]++;
            end
            @(posedge clk);
            for (int w = 0; w < 2; w++) begin
                if (ptr[w] < slots[w].size()) begin
                    code = slots[w][ptr[w]];
                    if (!(hold && code != DONEC)) ptr[w]++;
                end
            end
            cyc++;
        end
        if (cyc > BUDGET) check("timeout", 32'd1, 32'd0);
        #1;
        start = 1'b0;
        hold  = 1'($urandom_range(0, 1));
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            check($sformatf("idle_post_d%0d", w), 32'(obs(w)), 32'd0);
            check($sformatf("done_cyc_d%0d", w), 32'(done_at[w]),
                  (r == 0) ? 32'd1 : 32'(int'(r) * 4 + (int'(r) - 1) * gapv[w] + held[w] + 1));
            if (lb) check($sformatf("loopback_d%0d", w), 32'(hits[w]), 32'(r));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; seq = 16'h4321; rep = 4'd1; hold = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; start = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 2; w++) check($sformatf("reset_d%0d", w), 32'(obs(w)), 32'd0);

        run_tx(16'h4321, 4'd1, 0, 32'h0, 1'b0, 1'b1);
        run_tx(16'h9A5F, 4'd3, 0, 32'h0, 1'b0, 1'b1);
        run_tx(16'h4321, 4'd0, 0, 32'h0, 1'b0, 1'b1);
        run_tx(16'h9A5F, 4'd2, 0, 32'h0, 1'b0, 1'b1);
        run_tx(16'h4321, 4'd1, 0, 32'h1C, 1'b0, 1'b1);

        // abort during the third symbol
        @(posedge clk); #1;
        start = 1'b1; seq = 16'h4321; rep = 4'd1; hold = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 2; w++) check($sformatf("abort_sym3_d%0d", w), 32'(obs(w)), 32'h53);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 2; w++) check($sformatf("abort_clear_d%0d", w), 32'(obs(w)), 32'd0);
        repeat (6) begin
            @(negedge clk);
            for (int w = 0; w < 2; w++) check($sformatf("abort_quiet_d%0d", w), 32'(obs(w)), 32'd0);
        end

        run_tx(16'h4321, 4'd2, 0, 32'h0, 1'b1, 1'b1);
        run_tx(16'h1234, 4'd15, 10, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++)
            run_tx(16'($urandom), 4'($urandom_range(0, 5)), 25, 32'h0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
